// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register, the forwarding sources and the execute stage.
// Ports: ID/EX control and operands, the MEM and WB forward sources, and the EX/MEM
// and branch/busy results. The master modport drives inputs; the slave is ex_stage.
interface ex_stage_if;
    // ID/EX control
    logic        MR_in, MW_in, MemtoReg_in, regWE_in, aluSrc_in;
    logic        beq_in, bneq_in, bge_in, blt_in, jmp_in;
    logic [6:0]  opcode_in, func7_in;
    logic [2:0]  func3_in;
    logic [3:0]  alu_op_in;
    // ID/EX operands
    logic [31:0] pc_in, imm_in, rout1_in, rout2_in;
    logic [4:0]  rs1_in, rs2_in, rd_in;
    // forward sources
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    // stage results
    logic        ex_busy, branch_taken;
    logic [31:0] branch_target;
    logic        MR_out, MW_out, MemtoReg_out, regWE_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [4:0]  rd_out;

    modport master (
        output MR_in, MW_in, MemtoReg_in, regWE_in, aluSrc_in,
               beq_in, bneq_in, bge_in, blt_in, jmp_in,
               opcode_in, func7_in, func3_in, alu_op_in,
               pc_in, imm_in, rout1_in, rout2_in, rs1_in, rs2_in, rd_in,
               mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
        input  ex_busy, branch_taken, branch_target,
               MR_out, MW_out, MemtoReg_out, regWE_out,
               alu_result_out, store_data_out, rd_out
    );

    modport slave (
        input  MR_in, MW_in, MemtoReg_in, regWE_in, aluSrc_in,
               beq_in, bneq_in, bge_in, blt_in, jmp_in,
               opcode_in, func7_in, func3_in, alu_op_in,
               pc_in, imm_in, rout1_in, rout2_in, rs1_in, rs2_in, rd_in,
               mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
        output ex_busy, branch_taken, branch_target,
               MR_out, MW_out, MemtoReg_out, regWE_out,
               alu_result_out, store_data_out, rd_out
    );
endinterface

// File: rtl/ex_stage.sv
// RV32IM execute stage: forwarding, ALU, MUL/DIV, branch resolution, EX/MEM register.
// Latency: 1 edge for all ops; iterative divide takes 34 edges (EX_DIV_EN defined).
// Backpressure: ex_busy (combinational) holds upstream during a divide; EX/MEM gets bubbles.
// Ports: clk, rst (sync, active-high), bus (ex_stage_if.slave).
// Build option: define EX_DIV_EN for the 32-step restoring divider; otherwise divides return 0
// except the divisor-zero and signed-overflow cases.
module ex_stage (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    logic [31:0] w_fwd_a, w_fwd_b, w_op_a, w_op_b;
    logic [31:0] w_alu, w_result, w_div_out, w_div_special_res;
    logic        w_busy, w_div_special, w_div_zero, w_div_ovf, w_is_div;
    logic signed [65:0] w_mul_a, w_mul_b, w_mul_p;
    logic        w_take;

    // Forwarding: MEM beats WB, and x0 is never forwarded.
    always_comb begin
        w_fwd_a = bus.rout1_in;
        if (bus.rs1_in != 5'd0 && bus.mem_fwd_we && bus.mem_fwd_rd == bus.rs1_in)
            w_fwd_a = bus.mem_fwd_data;
        else if (bus.rs1_in != 5'd0 && bus.wb_fwd_we && bus.wb_fwd_rd == bus.rs1_in)
            w_fwd_a = bus.wb_fwd_data;

        w_fwd_b = bus.rout2_in;
        if (bus.rs2_in != 5'd0 && bus.mem_fwd_we && bus.mem_fwd_rd == bus.rs2_in)
            w_fwd_b = bus.mem_fwd_data;
        else if (bus.rs2_in != 5'd0 && bus.wb_fwd_we && bus.wb_fwd_rd == bus.rs2_in)
            w_fwd_b = bus.wb_fwd_data;
    end

    assign w_op_a = w_fwd_a;
    assign w_op_b = bus.aluSrc_in ? bus.imm_in : w_fwd_b;

    // One signed 66-bit multiplier covers all four MUL variants: the operand is
    // sign-extended only where that variant treats it as signed (func3 0 is low half, any).
    assign w_mul_a = {{34{w_op_a[31] & (bus.func3_in[1:0] != 2'b11)}}, w_op_a};
    assign w_mul_b = {{34{w_op_b[31] & ~bus.func3_in[1]}}, w_op_b};
    assign w_mul_p = w_mul_a * w_mul_b;

    // Divide special cases finish in one cycle in every build.
    assign w_is_div   = (bus.alu_op_in == 4'd12) && bus.func3_in[2];
    assign w_div_zero = (w_op_b == 32'd0);
    assign w_div_ovf  = ~bus.func3_in[0] && (w_op_a == 32'h8000_0000) && (w_op_b == 32'hFFFF_FFFF);
    assign w_div_special = w_div_zero || w_div_ovf;
    always_comb begin
        if (w_div_zero)
            w_div_special_res = bus.func3_in[1] ? w_op_a : 32'hFFFF_FFFF;
        else
            w_div_special_res = bus.func3_in[1] ? 32'd0 : 32'h8000_0000;
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} div_state_t;

    div_state_t  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo, r_rem, r_dvs;
    logic        r_neg_q, r_neg_r, r_is_rem;
    logic        w_div_start, w_signed;
    logic [32:0] w_rem_sh, w_sub;
    logic [31:0] w_q_fix, w_r_fix;

    assign w_signed    = ~bus.func3_in[0];
    assign w_div_start = (r_state == S_IDLE) && w_is_div && !w_div_special;
    assign w_busy      = w_div_start || (r_state == S_DIV);

    // Restoring step: shift the next dividend bit into the partial remainder and
    // subtract the divisor; bit 32 of the difference set means it did not fit.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_sub    = w_rem_sh - {1'b0, r_dvs};

    assign w_q_fix   = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_r_fix   = r_neg_r ? (32'd0 - r_rem) : r_rem;
    // In DONE the latched result wins; ID/EX still shows the divide but is not re-evaluated.
    assign w_div_out = (r_state == S_DONE) ? (r_is_rem ? w_r_fix : w_q_fix) : w_div_special_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_dvs    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_div_start) begin
                        r_quo    <= (w_signed && w_op_a[31]) ? (32'd0 - w_op_a) : w_op_a;
                        r_dvs    <= (w_signed && w_op_b[31]) ? (32'd0 - w_op_b) : w_op_b;
                        r_rem    <= 32'd0;
                        r_neg_q  <= w_signed && (w_op_a[31] ^ w_op_b[31]);
                        r_neg_r  <= w_signed && w_op_a[31];
                        r_is_rem <= bus.func3_in[1];
                        r_cnt    <= 5'd0;
                        r_state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (!w_sub[32]) begin
                        r_rem <= w_sub[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_busy    = 1'b0;
    assign w_div_out = w_div_special ? w_div_special_res : 32'd0;
`endif

    always_comb begin
        w_alu = 32'd0;
        case (bus.alu_op_in)
            4'd0:  w_alu = w_op_a + w_op_b;
            4'd1:  w_alu = w_op_a - w_op_b;
            4'd2:  w_alu = w_op_a << w_op_b[4:0];
            4'd3:  w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            4'd4:  w_alu = {31'd0, w_op_a < w_op_b};
            4'd5:  w_alu = w_op_a ^ w_op_b;
            4'd6:  w_alu = w_op_a >> w_op_b[4:0];
            4'd7:  w_alu = $signed(w_op_a) >>> w_op_b[4:0];
            4'd8:  w_alu = w_op_a | w_op_b;
            4'd9:  w_alu = w_op_a & w_op_b;
            4'd10: w_alu = w_op_b;
            4'd11: w_alu = bus.pc_in + w_op_b;
            4'd12: begin
                if (bus.func3_in[2])
                    w_alu = w_div_out;
                else if (bus.func3_in[1:0] == 2'b00)
                    w_alu = w_mul_p[31:0];
                else
                    w_alu = w_mul_p[63:32];
            end
            default: w_alu = 32'd0;
        endcase
    end

    assign w_result = bus.jmp_in ? (bus.pc_in + 32'd4) : w_alu;

    // Branches compare forwarded registers, never the immediate.
    assign w_take = bus.jmp_in
                  | (bus.beq_in  & (w_fwd_a == w_fwd_b))
                  | (bus.bneq_in & (w_fwd_a != w_fwd_b))
                  | (bus.bge_in  & ($signed(w_fwd_a) >= $signed(w_fwd_b)))
                  | (bus.blt_in  & ($signed(w_fwd_a) <  $signed(w_fwd_b)));

    assign bus.ex_busy       = w_busy;
    assign bus.branch_taken  = w_take & ~w_busy;
    assign bus.branch_target = w_busy ? 32'd0 :
                               (bus.opcode_in == OPC_JALR) ? ((w_fwd_a + bus.imm_in) & ~32'd1)
                                                           : (bus.pc_in + bus.imm_in);

    always_ff @(posedge clk) begin
        if (rst || w_busy) begin
            bus.MR_out         <= 1'b0;
            bus.MW_out         <= 1'b0;
            bus.MemtoReg_out   <= 1'b0;
            bus.regWE_out      <= 1'b0;
            bus.alu_result_out <= 32'd0;
            bus.store_data_out <= 32'd0;
            bus.rd_out         <= 5'd0;
        end else begin
            bus.MR_out         <= bus.MR_in;
            bus.MW_out         <= bus.MW_in;
            bus.MemtoReg_out   <= bus.MemtoReg_in;
            bus.regWE_out      <= bus.regWE_in;
            bus.alu_result_out <= w_result;
            bus.store_data_out <= w_fwd_b;
            bus.rd_out         <= bus.rd_in;
        end
    end

    logic w_unused_bits;
    assign w_unused_bits = ^{bus.func7_in, w_mul_p[65:64]};
endmodule
